// File: rtl/pc_gen_if.sv
// pc_gen_if: bundle between the branch/jump resolution logic (master) and the
// fetch PC generator (slave). Carries next-PC selection, exception/return
// requests and the generator's PC, EPC and return-address-stack outputs.
interface pc_gen_if #(
  parameter int WIDTH = 32
);

  logic             EN;
  logic [1:0]       PC_Sel;
  logic [WIDTH-1:0] PC_Branch;
  logic [WIDTH-1:0] JR;
  logic [WIDTH-1:0] PC_JAL;
  logic             EXC;
  logic [WIDTH-1:0] EXC_PC;
  logic             ERET;

  logic [WIDTH-1:0] PC_IF;
  logic [WIDTH-1:0] PC_4;
  logic [WIDTH-1:0] EPC;
  logic             IN_EXC;
  logic             MISALIGN;
  logic [WIDTH-1:0] RAS_TOP;
  logic             RAS_VALID;

  // Pipeline side: drives the requests, observes the PC state
  modport master (
    output EN, PC_Sel, PC_Branch, JR, PC_JAL, EXC, EXC_PC, ERET,
    input  PC_IF, PC_4, EPC, IN_EXC, MISALIGN, RAS_TOP, RAS_VALID
  );

  // PC generator side
  modport slave (
    input  EN, PC_Sel, PC_Branch, JR, PC_JAL, EXC, EXC_PC, ERET,
    output PC_IF, PC_4, EPC, IN_EXC, MISALIGN, RAS_TOP, RAS_VALID
  );

endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator for the MIPS150 front end.
// Holds the fetch PC and picks the next one from sequential, branch, JR or JAL
// targets, with exception vectoring (EPC capture / ERET return) and target
// alignment flagging. Priority each edge: RST > EXC > ERET > EN&PC_Sel > hold.
// Optional feature macro: PC_GEN_RAS_EN builds a circular return-address stack
// that pushes PC_4 on JAL and pops on JR; without it RAS_TOP/RAS_VALID are 0.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h4000_0000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h4000_0180),
  parameter int               RAS_DEPTH = 4
) (
  input logic      CLK,
  input logic      RST,
  pc_gen_if.slave  bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             in_exc_q, in_exc_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] pc4;

  // Only normal advancing cycles touch the return-address stack
  logic             adv;

  assign pc4 = pc_q + WIDTH'(4);
  assign adv = bus.EN && !bus.EXC && !bus.ERET;

  // Next-PC, EPC and exception-state selection in priority order
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    in_exc_d   = in_exc_q;
    misalign_d = 1'b0;
    if (bus.EXC) begin
      pc_d = EXC_VEC;
      if (!in_exc_q) begin
        epc_d    = bus.EXC_PC;
        in_exc_d = 1'b1;
      end
    end else if (bus.ERET) begin
      pc_d     = epc_q;
      in_exc_d = 1'b0;
    end else if (bus.EN) begin
      unique case (bus.PC_Sel)
        2'b00: pc_d = pc4;
        2'b01: begin
          pc_d       = {bus.PC_Branch[WIDTH-1:2], 2'b00};
          misalign_d = |bus.PC_Branch[1:0];
        end
        2'b10: begin
          pc_d       = {bus.JR[WIDTH-1:2], 2'b00};
          misalign_d = |bus.JR[1:0];
        end
        default: begin
          pc_d       = {bus.PC_JAL[WIDTH-1:2], 2'b00};
          misalign_d = |bus.PC_JAL[1:0];
        end
      endcase
    end
  end

  // PC and exception state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      in_exc_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      in_exc_q   <= in_exc_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.PC_IF    = pc_q;
  assign bus.PC_4     = pc4;
  assign bus.EPC      = epc_q;
  assign bus.IN_EXC   = in_exc_q;
  assign bus.MISALIGN = misalign_q;

`ifdef PC_GEN_RAS_EN
  // ptr_q is the next slot to write; the top lives one slot below it.
  // Depth is a power of two so the pointer wraps naturally, which makes a
  // push onto a full stack overwrite the oldest entry.
  localparam int PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic [PtrW-1:0]  top_idx;

  assign top_idx = ptr_q - 1'b1;

  // Push PC_4 on JAL, pop on JR; empty pops are ignored, count saturates
  always_comb begin
    ras_d = ras_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (adv) begin
      if (bus.PC_Sel == 2'b11) begin
        ras_d[ptr_q] = pc4;
        ptr_d        = ptr_q + 1'b1;
        if (cnt_q != FullCnt) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if ((bus.PC_Sel == 2'b10) && (cnt_q != '0)) begin
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Return-address stack storage, pointer and occupancy registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.RAS_VALID = (cnt_q != '0);
  assign bus.RAS_TOP   = (cnt_q != '0) ? ras_q[top_idx] : '0;
`else
  logic unused_adv;
  assign unused_adv    = adv;
  assign bus.RAS_TOP   = '0;
  assign bus.RAS_VALID = 1'b0;
`endif

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS150 fetch stage, replacing the fixed 32-bit PC register. It holds the fetch PC and selects the next PC from sequential, branch, JR or JAL targets under a stall enable. It adds exception vectoring with EPC capture and return, target alignment checking, and an optional return-address stack that provides JR target hints to the pipeline. It sits between the branch/jump resolution logic and the instruction memory address port.

## Interface
- WIDTH, 32: PC and target width in bits (≥ 8).
- RESET_VEC, 32'h4000_0000: PC value loaded on reset.
- EXC_VEC, 32'h4000_0180: PC value loaded on exception.
- RAS_DEPTH, 4: return-address stack entries (power of two, 2–16); used only when PC_GEN_RAS_EN is defined.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  advance enable; 0 = stall and hold the PC (exception and ERET still act).
- PC_Sel  in  2  next-PC select: 00 = PC_4, 01 = PC_Branch, 10 = JR, 11 = PC_JAL.
- PC_Branch, JR, PC_JAL  in  WIDTH  candidate targets.
- EXC  in  1  exception request, one-cycle pulse.
- EXC_PC  in  WIDTH  faulting PC to save in EPC.
- ERET  in  1  return-from-exception request.
- PC_IF  out  WIDTH  current fetch PC (registered).
- PC_4  out  WIDTH  PC_IF + 4, combinational, modulo 2^WIDTH.
- EPC  out  WIDTH  saved exception PC (registered).
- IN_EXC  out  1  exception handler active.
- MISALIGN  out  1  one-cycle pulse: the last loaded target had bits [1:0] ≠ 0.
- RAS_TOP  out  WIDTH  top of the return-address stack (0 when the stack is not built).
- RAS_VALID  out  1  stack non-empty (0 when the stack is not built).

## Operation
- Next-PC priority, evaluated each edge: RST > EXC > ERET > EN&PC_Sel > hold.
- RST: PC_IF=RESET_VEC, EPC=0, IN_EXC=0, MISALIGN=0, stack emptied (count=0, RAS_TOP=0, RAS_VALID=0).
- EXC: PC_IF=EXC_VEC. If IN_EXC=0, then EPC=EXC_PC and IN_EXC=1. If IN_EXC=1 (nested), EPC is kept and the PC still vectors. Stack is untouched.
- ERET (no EXC): PC_IF=EPC and IN_EXC=0. ERET with IN_EXC=0 still loads EPC.
- EN=1 and neither EXC nor ERET: PC_IF loads the target chosen by PC_Sel. Bits [1:0] of PC_Branch, JR and PC_JAL are forced to 00. MISALIGN is 1 for the next cycle if the raw bits [1:0] were non-zero. PC_4 is never flagged.
- EN=0 and neither EXC nor ERET: all state holds and MISALIGN=0.
- Return-address stack (when built): acts only on cycles where EN=1, EXC=0 and ERET=0.
  - PC_Sel=11: push PC_4 (the current PC_IF+4).
  - PC_Sel=10: pop.
  - Full push: the oldest entry is overwritten (circular); count saturates at RAS_DEPTH.
  - Pop when empty: no-op; RAS_TOP stays 0.
- PC_4 wraps modulo 2^WIDTH; the maximum aligned PC + 4 = 0.

## Timing
- One-cycle latency: a select or event at edge N shows on PC_IF after edge N. PC_4 follows PC_IF combinationally in the same cycle.
- EPC, IN_EXC, MISALIGN, RAS_TOP and RAS_VALID are registered and update on the same edge as PC_IF.
- EXC and ERET in the same cycle: EXC wins; ERET is ignored.
- RST asserted mid-exception or with a stack non-empty: every state element returns to its reset value on that edge.
- RST held: PC_IF stays at RESET_VEC; all inputs are ignored.
- The first fetch after reset deasserts is RESET_VEC.

## Configuration
- PC_GEN_RAS_EN defined: the RAS_DEPTH-entry stack, its pointer and its count are built; RAS_TOP and RAS_VALID are live.
- PC_GEN_RAS_EN undefined: no stack storage; RAS_TOP is tied to 0 and RAS_VALID to 0. All other behaviour is identical.

## Test plan
- Reset then sequential: RST=1 for 2 cycles, then EN=1, PC_Sel=00 for 3 cycles → PC_IF = 4000_0000, 4000_0004, 4000_0008, 4000_000C.
- Select and stall: EN=1, PC_Sel=01, PC_Branch=4000_0101 → PC_IF=4000_0100 and MISALIGN=1 for one cycle. Then EN=0 for 3 cycles → PC_IF holds 4000_0100 and MISALIGN=0.
- Exception, nesting and return: at PC 4000_0020, assert EXC with EXC_PC=4000_001C → PC_IF=4000_0180, EPC=4000_001C, IN_EXC=1. A second EXC with EXC_PC=4000_0184 → EPC is unchanged. ERET → PC_IF=4000_001C, IN_EXC=0.
- Priority: EXC, ERET and EN=1 with PC_Sel=11 all in one cycle → PC_IF=EXC_VEC and no stack push. RST together with EXC → PC_IF=RESET_VEC, IN_EXC=0.
- Stack (PC_GEN_RAS_EN, RAS_DEPTH=4): five JALs issued from PCs 0x100, 0x200, 0x300, 0x400, 0x500 → RAS_TOP=0x504. Then five JRs → RAS_TOP sequence 0x404, 0x304, 0x204, 0 with RAS_VALID falling after the fourth pop; the fifth pop is a no-op.
- Wrap: PC_IF=FFFF_FFFC with PC_Sel=00 → PC_4=0 and next PC_IF=0000_0000.
